// File: rtl/olm_pkg.sv
// Shared types and defaults for the online-multiplier sequencer.
//   olm_state_t : controller states IDLE -> INIT -> RUN -> DONE
//   OLM_N       : default operand digit count
//   OLM_DELTA   : default online delay
//   olm_cw()    : width of a step counter that must hold 0..N+DELTA
package olm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } olm_state_t;

  localparam int OLM_N     = 8;
  localparam int OLM_DELTA = 3;

  function automatic int olm_cw(input int n, input int d);
    return $clog2(n + d + 1);
  endfunction

endpackage

// File: rtl/olm_step_cnt.sv
// Online step counter j for the multiplier sequencer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force j to 0 (takes priority over en)
//   en       : advance j by one
//   cnt      : current step index j
//   term     : j is the final step (N+DELTA-1)
//   need_in  : j < N, an input digit pair is consumed this step
//   emit     : j >= DELTA, a product digit is produced this step
module olm_step_cnt
  import olm_pkg::*;
#(
  parameter int N     = OLM_N,
  parameter int DELTA = OLM_DELTA,
  parameter int CW    = olm_cw(OLM_N, OLM_DELTA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          term,
  output logic          need_in,
  output logic          emit
);

  localparam logic [CW-1:0] LAST_J  = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] N_J     = CW'(N);
  localparam logic [CW-1:0] DELTA_J = CW'(DELTA);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign term    = (cnt_q == LAST_J);
  assign need_in = (cnt_q < N_J);
  assign emit    = (cnt_q >= DELTA_J);

endmodule

// File: rtl/olm_seq_ctrl.sv
// Sequencer for one digit-serial MSDF online multiplier slice.
// Accepts N signed digit pairs, pads DELTA zero digits, and emits N
// product digits once the online delay has elapsed.
// Optional build macro: OLM_STALL_CNT_EN adds a saturating stall counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin an operation (honoured only in IDLE)
//   in_valid   : upstream digit pair valid    / in_ready : pair accepted
//   out_ready  : downstream accepts digit     / out_valid: product digit valid
//   init_clr   : one-cycle clear of residual and operand registers
//   step_en    : datapath advances one online step
//   pad_zero   : datapath substitutes zero digits for x/y
//   last       : qualifies the final product digit
//   busy, done : operation in progress / one-cycle completion pulse
//   step_cnt   : current step index j
//   stall_cnt  : (OLM_STALL_CNT_EN only) RUN cycles without a step
module olm_seq_ctrl
  import olm_pkg::*;
#(
  parameter  int N     = OLM_N,
  parameter  int DELTA = OLM_DELTA,
  localparam int CW    = olm_cw(N, DELTA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          init_clr,
  output logic          step_en,
  output logic          pad_zero,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] step_cnt
`ifdef OLM_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  olm_state_t state_q, state_d;
  logic       cnt_clr;
  logic       term;
  logic       need_in;
  logic       emit;

  olm_step_cnt #(
    .N     (N),
    .DELTA (DELTA),
    .CW    (CW)
  ) u_step_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (step_en),
    .cnt     (step_cnt),
    .term    (term),
    .need_in (need_in),
    .emit    (emit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    init_clr  = 1'b0;
    step_en   = 1'b0;
    in_ready  = 1'b0;
    pad_zero  = 1'b0;
    out_valid = 1'b0;
    last      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        init_clr = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        in_ready  = need_in;
        pad_zero  = !need_in;
        // During the pad phase no input is needed, so only the output side
        // can stall; during the input phase a missing pair blocks both.
        out_valid = emit && (!need_in || in_valid);
        step_en   = (!need_in || in_valid) && (!emit || out_ready);
        last      = out_valid && term;
        if (step_en && term) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        // j returns to 0 so that IDLE always shows step_cnt = 0.
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef OLM_STALL_CNT_EN
  // Value is kept after DONE so software can read it until the next INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (state_q == INIT) begin
      stall_cnt <= 16'd0;
    end else if ((state_q == RUN) && !step_en && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_olm_seq_ctrl.sv
// Self-checking bench for olm_seq_ctrl (N=8, DELTA=3). Each cycle's
// stimulus and expected outputs are planned as one record; the record is
// queued as expectation when driven and compared at the falling edge.
// Build with +define+OLM_STALL_CNT_EN to also check stall_cnt.
module tb_olm_seq_ctrl;

  localparam int N    = 8;
  localparam int D    = 3;
  localparam int LAST = N + D - 1;

  localparam logic [7:0] F_INIT = 8'h80;
  localparam logic [7:0] F_STEP = 8'h40;
  localparam logic [7:0] F_IRDY = 8'h20;
  localparam logic [7:0] F_PAD  = 8'h10;
  localparam logic [7:0] F_OV   = 8'h08;
  localparam logic [7:0] F_LAST = 8'h04;
  localparam logic [7:0] F_BUSY = 8'h02;
  localparam logic [7:0] F_DONE = 8'h01;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, out_valid, init_clr, step_en, pad_zero, last, busy, done;
  logic [3:0] step_cnt;
`ifdef OLM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // val/mask layout: {flags[7:0], step_cnt[3:0], stall_cnt[15:0]}
  typedef struct {
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic        rst;
    logic [27:0] val;
    logic [27:0] mask;
  } rec_t;

  rec_t plan[$];
  rec_t exp_q[$];

  always #5 clk = ~clk;

  olm_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .init_clr  (init_clr),
    .step_en   (step_en),
    .pad_zero  (pad_zero),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .step_cnt  (step_cnt)
`ifdef OLM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [27:0] sample();
    logic [15:0] s;
    s = 16'd0;
`ifdef OLM_STALL_CNT_EN
    s = stall_cnt;
`endif
    return {init_clr, step_en, in_ready, pad_zero, out_valid, last, busy, done,
            step_cnt, s};
  endfunction

  // stall < 0 means stall_cnt is not checked on this cycle
  task automatic add(input logic st, input logic iv, input logic ordy,
                     input logic r, input logic [7:0] fl, input int j,
                     input int stall);
    rec_t e;
    e.start     = st;
    e.in_valid  = iv;
    e.out_ready = ordy;
    e.rst       = r;
    e.val       = {fl, 4'(j), (stall < 0) ? 16'd0 : 16'(stall)};
    e.mask      = {12'hFFF, 16'h0000};
`ifdef OLM_STALL_CNT_EN
    if (stall >= 0) e.mask[15:0] = 16'hFFFF;
`endif
    plan.push_back(e);
  endtask

  task automatic push_idle(input logic st);
    add(st, 1'b1, 1'b1, 1'b0, 8'h00, 0, -1);
  endtask

  // One operation from INIT onwards. Input stalls must sit at j<N and
  // output stalls at j>=DELTA. start_j pulses start on that step,
  // abort_j asserts rst on that step and ends the plan there.
  task automatic push_op(input int in_j, input int in_n, input int out_j,
                         input int out_n, input int start_j, input int abort_j,
                         input logic done_start);
    logic [7:0] fl;
    add(1'b0, 1'b1, 1'b1, 1'b0, F_INIT | F_BUSY, 0, -1);
    for (int j = 0; j <= LAST; j++) begin
      if (j == in_j)
        for (int k = 0; k < in_n; k++)
          add(1'b0, 1'b0, 1'b1, 1'b0, F_IRDY | F_BUSY, j, -1);
      if (j == out_j)
        for (int k = 0; k < out_n; k++) begin
          fl = F_BUSY | F_OV;
          if (j < N) fl |= F_IRDY; else fl |= F_PAD;
          if (j == LAST) fl |= F_LAST;
          add(1'b0, 1'b1, 1'b0, 1'b0, fl, j, -1);
        end
      fl = F_BUSY | F_STEP;
      if (j < N) fl |= F_IRDY; else fl |= F_PAD;
      if (j >= D) fl |= F_OV;
      if (j == LAST) fl |= F_LAST;
      add(j == start_j, 1'b1, 1'b1, j == abort_j, fl, j, (j == 0) ? 0 : -1);
      if (j == abort_j) return;
    end
    add(done_start, 1'b1, 1'b1, 1'b0, F_DONE | F_BUSY, N + D, in_n + out_n);
  endtask

  task automatic drive_next();
    rec_t r;
    r = plan.pop_front();
    start     = r.start;
    in_valid  = r.in_valid;
    out_ready = r.out_ready;
    rst       = r.rst;
    exp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nominal();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);
    push_op(-1, 0, -1, 0, -1, -1, 1'b0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL nominal cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_in_stall();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);
    push_op(4, 2, -1, 0, -1, -1, 1'b0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL in_stall cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_out_stall();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);
    push_op(-1, 0, 9, 3, -1, -1, 1'b0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL out_stall cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_ignore();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);                         // cycle 0 accepted
    push_op(-1, 0, -1, 0, 3, -1, 1'b1);      // cycle 5 (j=3) and 13 (DONE) ignored
    push_idle(1'b1);                         // cycle 14 accepted, INIT at 15
    push_op(-1, 0, -1, 0, -1, -1, 1'b0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL start_ignore cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_abort();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);                         // cycle 0
    push_op(-1, 0, -1, 0, -1, 5, 1'b0);      // rst during cycle 7 (j=5)
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0); // cycle 8: all idle, no done
    push_idle(1'b1);                         // cycle 9
    push_op(-1, 0, -1, 0, -1, -1, 1'b0);
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL rst_abort cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_combined();
    logic [27:0] obs;
    rec_t        ex;
    int          cyc = 0;
    push_idle(1'b1);
    push_op(4, 2, 9, 3, -1, -1, 1'b0);       // 5 stall cycles, DONE expects 5
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 5); // count held in IDLE
    push_op(-1, 0, -1, 0, -1, -1, 1'b0);     // cleared by INIT (0 at j=0)
    push_idle(1'b0);
    while (plan.size() > 0) begin
      drive_next();
      obs = sample();
      ex  = exp_q.pop_front();
      checks++;
      if ((obs & ex.mask) !== (ex.val & ex.mask)) begin
        errors++;
        $display("FAIL stall_combined cyc %0d: got %h want %h", cyc, obs & ex.mask, ex.val & ex.mask);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_in_stall();
    test_out_stall();
    test_start_ignore();
    test_rst_abort();
    test_stall_combined();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
